// File: rtl/word32_8bits_arb.sv
// Two-lane 32-bit word to byte serializer with round-robin arbitration.
// Each lane has a one-word holding buffer. Granted words leave MSB first,
// one byte per cycle. A new word can be granted on the last byte of the
// current one, so there is no gap between consecutive words.
module word32_8bits_arb #(
  parameter logic [7:0] IDLE_BYTE = 8'h00,
  parameter logic       RR_INIT   = 1'b0
) (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic        valid_in0,
  input  logic [31:0] Data_in0,
  output logic        ready_out0,
  input  logic        valid_in1,
  input  logic [31:0] Data_in1,
  output logic        ready_out1,
  output logic        valid_out,
  output logic [7:0]  Data_out,
  output logic        lane_out
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        full_q, full_d;
  logic [1:0][31:0]  buf_q, buf_d;
  logic [31:0]       sh_q, sh_d;
  logic              rr_q, rr_d;
  logic              vout_q, vout_d;
  logic              lane_q, lane_d;
  logic [7:0]        dout_q, dout_d;

  logic [1:0]        acc;
  logic [1:0]        gsel;
  logic              gnt, gnt_lane, slot;

  // A full buffer never accepts, so accept and grant never hit the same lane.
  assign ready_out0 = reset_L & ~full_q[0];
  assign ready_out1 = reset_L & ~full_q[1];
  assign acc        = {valid_in1 & ready_out1, valid_in0 & ready_out0};

  // Arbitration: a slot opens when idle or on the last byte of a word.
  always_comb begin
    gnt      = 1'b0;
    gnt_lane = 1'b0;
    slot     = (state_q == IDLE) || (cnt_q == 2'd3);
    if (slot) begin
      case (full_q)
        2'b01:   begin gnt = 1'b1; gnt_lane = 1'b0; end
        2'b10:   begin gnt = 1'b1; gnt_lane = 1'b1; end
        2'b11:   begin gnt = 1'b1; gnt_lane = rr_q; end
        default: ;
      endcase
    end
    gsel = gnt ? (gnt_lane ? 2'b10 : 2'b01) : 2'b00;
  end

  // Holding buffers: load on accept, release on grant.
  always_comb begin
    full_d   = (full_q & ~gsel) | acc;
    buf_d    = buf_q;
    if (acc[0]) buf_d[0] = Data_in0;
    if (acc[1]) buf_d[1] = Data_in1;
  end

  // Serializer FSM next-state and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rr_d    = rr_q;
    vout_d  = vout_q;
    lane_d  = lane_q;
    dout_d  = dout_q;
    if (gnt) begin
      sh_d    = buf_q[gnt_lane];
      dout_d  = buf_q[gnt_lane][31:24];
      vout_d  = 1'b1;
      lane_d  = gnt_lane;
      cnt_d   = 2'd0;
      rr_d    = ~gnt_lane;
      state_d = SEND;
    end else if (state_q == SEND && cnt_q != 2'd3) begin
      // Shift so the next byte is always at [23:16].
      sh_d   = {sh_q[23:0], 8'h00};
      dout_d = sh_q[23:16];
      cnt_d  = cnt_q + 2'd1;
    end else begin
      vout_d  = 1'b0;
      dout_d  = IDLE_BYTE;
      cnt_d   = 2'd0;
      state_d = IDLE;
    end
  end

  // State registers; reset aborts any word in flight and empties buffers.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      full_q  <= 2'b00;
      buf_q   <= '0;
      sh_q    <= 32'h0;
      rr_q    <= RR_INIT;
      vout_q  <= 1'b0;
      lane_q  <= 1'b0;
      dout_q  <= IDLE_BYTE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      buf_q   <= buf_d;
      sh_q    <= sh_d;
      rr_q    <= rr_d;
      vout_q  <= vout_d;
      lane_q  <= lane_d;
      dout_q  <= dout_d;
    end
  end

  assign valid_out = vout_q;
  assign Data_out  = dout_q;
  assign lane_out  = lane_q;

endmodule

// File: tb/tb_word32_8bits_arb.sv
// Scoreboard bench: a word-level reference model queues expected bytes,
// a negedge monitor pops and compares whenever the DUT shows valid_out.
module tb_word32_8bits_arb;

  localparam logic [7:0] IDLE = 8'h00;

  logic        clk_4f = 1'b0;
  logic        reset_L;
  logic [1:0]  vin;
  logic [31:0] din [2];
  logic        ready_out0, ready_out1, valid_out, lane_out;
  logic [7:0]  Data_out;

  int vecs = 0;
  int errs = 0;

  word32_8bits_arb dut (
    .clk_4f(clk_4f), .reset_L(reset_L),
    .valid_in0(vin[0]), .Data_in0(din[0]), .ready_out0(ready_out0),
    .valid_in1(vin[1]), .Data_in1(din[1]), .ready_out1(ready_out1),
    .valid_out(valid_out), .Data_out(Data_out), .lane_out(lane_out)
  );

  always #5 clk_4f = ~clk_4f;

  // Reference model: pending word per lane, remaining bytes of current word.
  logic [31:0] m_q0[$], m_q1[$];
  logic [8:0]  exp_q[$];
  int          rem = 0;
  bit          rr  = 1'b0;

  always @(posedge clk_4f or negedge reset_L) begin
    bit a0, a1, g, l;
    logic [31:0] w;
    if (!reset_L) begin
      m_q0.delete(); m_q1.delete(); exp_q.delete();
      rem = 0; rr = 1'b0;
    end else begin
      a0 = vin[0] && (m_q0.size() == 0);
      a1 = vin[1] && (m_q1.size() == 0);
      g = 1'b0; l = 1'b0; w = 32'h0;
      if (rem <= 1) begin
        if (m_q0.size() > 0 && m_q1.size() > 0) begin g = 1'b1; l = rr; end
        else if (m_q0.size() > 0)               begin g = 1'b1; l = 1'b0; end
        else if (m_q1.size() > 0)               begin g = 1'b1; l = 1'b1; end
        if (g) begin
          if (l) w = m_q1.pop_front();
          else   w = m_q0.pop_front();
          for (int b = 3; b >= 0; b--) exp_q.push_back({l, w[8*b +: 8]});
          rem = 4;
          rr  = !l;
        end else rem = 0;
      end else rem--;
      if (a0) m_q0.push_back(din[0]);
      if (a1) m_q1.push_back(din[1]);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk_4f) begin
    logic [8:0] e;
    chk("ready0", 32'(ready_out0), 32'(reset_L && m_q0.size() == 0));
    chk("ready1", 32'(ready_out1), 32'(reset_L && m_q1.size() == 0));
    chk("valid",  32'(valid_out),  32'(rem > 0));
    if (!reset_L) chk("rst_lane", 32'(lane_out), 32'h0);
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL byte: got %h with empty scoreboard at %0t", Data_out, $time);
      end else begin
        e = exp_q.pop_front();
        chk("byte", 32'(Data_out), 32'(e[7:0]));
        chk("lane", 32'(lane_out), 32'(e[8]));
      end
    end else begin
      chk("idle_byte", 32'(Data_out), 32'(IDLE));
    end
  end

  // Stimulus
  logic [31:0] src0[$], src1[$];
  logic [1:0]  rdy_pre = 2'b00;

  task automatic run(int n, int p0, int p1, bit churn);
    int p [2];
    p[0] = p0; p[1] = p1;
    repeat (n) begin
      for (int i = 0; i < 2; i++) begin
        if (vin[i] && rdy_pre[i]) vin[i] = 1'b0;
        if (!vin[i]) begin
          if (i == 0 && src0.size() > 0) begin vin[0] = 1'b1; din[0] = src0.pop_front(); end
          else if (i == 1 && src1.size() > 0) begin vin[1] = 1'b1; din[1] = src1.pop_front(); end
          else if (p[i] > 0 && int'($urandom_range(99)) < p[i]) begin
            vin[i] = 1'b1; din[i] = $urandom;
          end else din[i] = $urandom;
        end else if (churn) din[i] = $urandom;
      end
      rdy_pre = {ready_out1, ready_out0};
      @(posedge clk_4f); #2;
    end
  endtask

  task automatic pulse_reset(int n);
    reset_L = 1'b0; vin = 2'b00; rdy_pre = 2'b00;
    repeat (n) begin @(posedge clk_4f); #2; end
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L = 1'b0; vin = 2'b00; din[0] = 32'h0; din[1] = 32'h0;
    repeat (3) begin @(posedge clk_4f); #2; end
    reset_L = 1'b1;

    // single word on lane 0
    src0.push_back(32'hDEADBEEF);
    run(10, 0, 0, 1'b0);

    // simultaneous arrival after reset
    pulse_reset(2);
    src0.push_back(32'h01020304); src1.push_back(32'hA1A2A3A4);
    run(12, 0, 0, 1'b0);

    // fairness: 8 words on each lane
    pulse_reset(2);
    for (int i = 0; i < 8; i++) begin
      src0.push_back(32'h10000000 + i); src1.push_back(32'h20000000 + i);
    end
    run(80, 0, 0, 1'b0);

    // backpressure with changing stalled data on lane 1
    run(60, 30, 100, 1'b1);
    run(10, 0, 0, 1'b0);

    // back-to-back on a single lane
    pulse_reset(2);
    run(40, 100, 0, 1'b0);
    run(10, 0, 0, 1'b0);

    // reset in the middle of a word
    src0.push_back(32'hCAFEF00D);
    run(3, 0, 0, 1'b0);
    pulse_reset(2);
    run(10, 0, 0, 1'b0);

    // random traffic
    run(400, 40, 60, 1'b1);
    run(300, 90, 90, 1'b1);
    run(20, 0, 0, 1'b0);

    chk("drain", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
